// File: rtl/alarme_pkg.sv
// Shared definitions for the alarm controller: FSM state codes, timer width
// and the default values of the timing/attempt parameters.
package alarme_pkg;

  localparam int unsigned TimerWidth = 9;

  localparam int unsigned TEMPO_SAIDA_DEF    = 180;
  localparam int unsigned TEMPO_ENTRADA_DEF  = 30;
  localparam int unsigned TEMPO_SIRENE_DEF   = 300;
  localparam int unsigned MAX_TENTATIVAS_DEF = 3;
  localparam int unsigned TEMPO_BLOQUEIO_DEF = 60;

  typedef enum logic [2:0] {
    StDesarmado = 3'd0,
    StSaida     = 3'd1,
    StArmado    = 3'd2,
    StEntrada   = 3'd3,
    StDisparo   = 3'd4
  } estado_e;

  // States whose timer counts down on tick_1s.
  function automatic logic estado_temporizado(estado_e st);
    return (st == StSaida) || (st == StEntrada) || (st == StDisparo);
  endfunction

endpackage

// File: rtl/contador_regressivo.sv
// Loadable down-counter with tick enable.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : force count to zero (highest priority)
//   load_i        : load load_val_i
//   load_val_i    : value to load
//   tick_i        : decrement by one, saturating at zero
//   count_o       : current count (registered)
//   zero_o        : count_o == 0
module contador_regressivo #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             tick_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/controle_alarme.sv
// Burglar alarm controller: arm/disarm by password, exit and entry delays,
// timed siren, panic input and wrong-password lockout.
//   clock, reset_n  : clock, asynchronous active-low reset
//   tick_1s         : one-cycle pulse per second
//   confirma        : user confirms the entered digits
//   senha_igual     : entered digits match the stored password
//   sensor[3:0]     : zone sensors, active high
//   panico          : panic button, active high
//   estado          : FSM state code
//   armado, sirene  : armed indicator, siren drive
//   bloqueado       : wrong-password lockout active
//   tempo_restante  : seconds left in the current timed state
//   tentativas      : current wrong-attempt count
//   limpa_digitos   : one-cycle pulse after every accepted confirma
module controle_alarme
  import alarme_pkg::*;
#(
  parameter int unsigned TEMPO_SAIDA    = TEMPO_SAIDA_DEF,
  parameter int unsigned TEMPO_ENTRADA  = TEMPO_ENTRADA_DEF,
  parameter int unsigned TEMPO_SIRENE   = TEMPO_SIRENE_DEF,
  parameter int unsigned MAX_TENTATIVAS = MAX_TENTATIVAS_DEF,
  parameter int unsigned TEMPO_BLOQUEIO = TEMPO_BLOQUEIO_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_1s,
  input  logic       confirma,
  input  logic       senha_igual,
  input  logic [3:0] sensor,
  input  logic       panico,
  output logic [2:0] estado,
  output logic       armado,
  output logic       sirene,
  output logic       bloqueado,
  output logic [8:0] tempo_restante,
  output logic [1:0] tentativas,
  output logic       limpa_digitos
);

  localparam logic [TimerWidth-1:0] ValSaida    = TimerWidth'(TEMPO_SAIDA);
  localparam logic [TimerWidth-1:0] ValEntrada  = TimerWidth'(TEMPO_ENTRADA);
  localparam logic [TimerWidth-1:0] ValSirene   = TimerWidth'(TEMPO_SIRENE);
  localparam logic [TimerWidth-1:0] ValBloqueio = TimerWidth'(TEMPO_BLOQUEIO);
  localparam logic [1:0]            MaxTent     = 2'(MAX_TENTATIVAS);

  estado_e         estado_d, estado_q;
  logic [1:0]      tentativas_d, tentativas_q;
  logic            bloqueado_d, bloqueado_q;
  logic            armado_d, armado_q;
  logic            sirene_d, sirene_q;
  logic            limpa_d, limpa_q;

  logic            aceito, valido, errado, entra_bloqueio;
  logic [1:0]      tent_inc;

  logic                  timer_clear, timer_load, timer_tick;
  logic [TimerWidth-1:0] timer_val, timer_count;
  logic                  timer_zero;

  logic                  lock_load, lock_tick;
  logic [TimerWidth-1:0] lock_count;
  logic                  lock_zero;

  // Confirma is discarded entirely while locked out.
  assign aceito         = confirma & ~bloqueado_q;
  assign valido         = aceito & senha_igual;
  assign errado         = aceito & ~senha_igual;
  assign tent_inc       = tentativas_q + 2'd1;
  assign entra_bloqueio = errado && (tent_inc == MaxTent);

  // Main FSM; the if/else chain encodes the per-cycle priority
  // panic > valid password > lockout entry > sensor > timer expiry.
  always_comb begin
    estado_d    = estado_q;
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_val   = '0;
    timer_tick  = 1'b0;

    if (!(estado_q inside {StDesarmado, StSaida, StArmado, StEntrada, StDisparo})) begin
      estado_d    = StDesarmado;
      timer_clear = 1'b1;
    end else if (panico) begin
      estado_d   = StDisparo;
      timer_load = 1'b1;
      timer_val  = ValSirene;
    end else if (valido) begin
      if (estado_q == StDesarmado) begin
        estado_d   = StSaida;
        timer_load = 1'b1;
        timer_val  = ValSaida;
      end else begin
        estado_d    = StDesarmado;
        timer_clear = 1'b1;
      end
    end else if (entra_bloqueio && (estado_q inside {StArmado, StEntrada})) begin
      estado_d   = StDisparo;
      timer_load = 1'b1;
      timer_val  = ValSirene;
    end else if ((estado_q == StArmado) && (sensor != 4'b0000)) begin
      estado_d   = StEntrada;
      timer_load = 1'b1;
      timer_val  = ValEntrada;
    end else if (tick_1s && estado_temporizado(estado_q)) begin
      // A tick seen with one second left expires the state; zero is only
      // treated as expired defensively.
      if ((timer_count == TimerWidth'(1)) || timer_zero) begin
        unique case (estado_q)
          StSaida: begin
            estado_d    = StArmado;
            timer_clear = 1'b1;
          end
          StEntrada: begin
            estado_d   = StDisparo;
            timer_load = 1'b1;
            timer_val  = ValSirene;
          end
          default: begin
            estado_d    = StArmado;
            timer_clear = 1'b1;
          end
        endcase
      end else begin
        timer_tick = 1'b1;
      end
    end
  end

  // Attempt counter, lockout flag and registered output decode.
  always_comb begin
    tentativas_d = tentativas_q;
    bloqueado_d  = bloqueado_q;
    lock_load    = 1'b0;
    lock_tick    = tick_1s & bloqueado_q;

    if (valido) begin
      tentativas_d = 2'd0;
    end else if (errado) begin
      tentativas_d = entra_bloqueio ? 2'd0 : tent_inc;
    end

    if (entra_bloqueio) begin
      bloqueado_d = 1'b1;
      lock_load   = 1'b1;
    end else if (bloqueado_q &&
                 (lock_zero || (tick_1s && (lock_count == TimerWidth'(1))))) begin
      bloqueado_d = 1'b0;
    end

    armado_d = (estado_d == StArmado) || (estado_d == StEntrada);
    sirene_d = (estado_d == StDisparo);
    limpa_d  = aceito;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= StDesarmado;
      tentativas_q <= 2'd0;
      bloqueado_q  <= 1'b0;
      armado_q     <= 1'b0;
      sirene_q     <= 1'b0;
      limpa_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      tentativas_q <= tentativas_d;
      bloqueado_q  <= bloqueado_d;
      armado_q     <= armado_d;
      sirene_q     <= sirene_d;
      limpa_q      <= limpa_d;
    end
  end

  contador_regressivo #(
    .Width (TimerWidth)
  ) u_timer_fsm (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .clear_i    (timer_clear),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tick_i     (timer_tick),
    .count_o    (timer_count),
    .zero_o     (timer_zero)
  );

  contador_regressivo #(
    .Width (TimerWidth)
  ) u_timer_bloqueio (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .clear_i    (1'b0),
    .load_i     (lock_load),
    .load_val_i (ValBloqueio),
    .tick_i     (lock_tick),
    .count_o    (lock_count),
    .zero_o     (lock_zero)
  );

  assign estado         = estado_q;
  assign armado         = armado_q;
  assign sirene         = sirene_q;
  assign bloqueado      = bloqueado_q;
  assign tempo_restante = timer_count;
  assign tentativas     = tentativas_q;
  assign limpa_digitos  = limpa_q;

endmodule

// File: tb/tb_controle_alarme.sv
// Directed self-checking bench for controle_alarme with short timing
// parameters (exit 3 s, entry 2 s, siren 4 s, lockout 5 s, 3 attempts).
module tb_controle_alarme;

  logic       clock;
  logic       reset_n;
  logic       tick_1s;
  logic       confirma;
  logic       senha_igual;
  logic [3:0] sensor;
  logic       panico;
  logic [2:0] estado;
  logic       armado;
  logic       sirene;
  logic       bloqueado;
  logic [8:0] tempo_restante;
  logic [1:0] tentativas;
  logic       limpa_digitos;

  int errors = 0;
  int checks = 0;
  logic watch_sirene = 1'b0;
  logic saw_sirene   = 1'b0;

  controle_alarme #(
    .TEMPO_SAIDA    (3),
    .TEMPO_ENTRADA  (2),
    .TEMPO_SIRENE   (4),
    .MAX_TENTATIVAS (3),
    .TEMPO_BLOQUEIO (5)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .tick_1s        (tick_1s),
    .confirma       (confirma),
    .senha_igual    (senha_igual),
    .sensor         (sensor),
    .panico         (panico),
    .estado         (estado),
    .armado         (armado),
    .sirene         (sirene),
    .bloqueado      (bloqueado),
    .tempo_restante (tempo_restante),
    .tentativas     (tentativas),
    .limpa_digitos  (limpa_digitos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (watch_sirene && sirene) saw_sirene <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock cycle with the given pulse inputs; returns 1 ns after the edge.
  task automatic cyc(input logic t, input logic c, input logic s);
    tick_1s = t; confirma = c; senha_igual = s;
    @(posedge clock); #1;
    tick_1s = 1'b0; confirma = 1'b0; senha_igual = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tick_1s = 1'b0; confirma = 1'b0; senha_igual = 1'b0;
    sensor = 4'b0000; panico = 1'b0;
    #3;
    checks++; if (estado !== 3'd0) begin errors++;
      $display("FAIL reset_estado: got %0d want 0", estado); end
    checks++; if (armado !== 1'b0) begin errors++;
      $display("FAIL reset_armado: got %b want 0", armado); end
    checks++; if (sirene !== 1'b0) begin errors++;
      $display("FAIL reset_sirene: got %b want 0", sirene); end
    checks++; if (bloqueado !== 1'b0) begin errors++;
      $display("FAIL reset_bloqueado: got %b want 0", bloqueado); end
    checks++; if (tempo_restante !== 9'd0) begin errors++;
      $display("FAIL reset_tempo: got %0d want 0", tempo_restante); end
    checks++; if (tentativas !== 2'd0) begin errors++;
      $display("FAIL reset_tentativas: got %0d want 0", tentativas); end
    checks++; if (limpa_digitos !== 1'b0) begin errors++;
      $display("FAIL reset_limpa: got %b want 0", limpa_digitos); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_arm();
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (estado !== 3'd1) begin errors++;
      $display("FAIL arm_estado_saida: got %0d want 1", estado); end
    checks++; if (tempo_restante !== 9'd3) begin errors++;
      $display("FAIL arm_tempo3: got %0d want 3", tempo_restante); end
    checks++; if (limpa_digitos !== 1'b1) begin errors++;
      $display("FAIL arm_limpa_pulse: got %b want 1", limpa_digitos); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (tempo_restante !== 9'd2) begin errors++;
      $display("FAIL arm_tempo2: got %0d want 2", tempo_restante); end
    checks++; if (limpa_digitos !== 1'b0) begin errors++;
      $display("FAIL arm_limpa_single: got %b want 0", limpa_digitos); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (tempo_restante !== 9'd1) begin errors++;
      $display("FAIL arm_tempo1: got %0d want 1", tempo_restante); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (estado !== 3'd2) begin errors++;
      $display("FAIL arm_estado_armado: got %0d want 2", estado); end
    checks++; if (armado !== 1'b1) begin errors++;
      $display("FAIL arm_armado: got %b want 1", armado); end
    checks++; if (tempo_restante !== 9'd0) begin errors++;
      $display("FAIL arm_tempo0: got %0d want 0", tempo_restante); end
  endtask

  task automatic test_sensor();
    sensor = 4'b0100;
    cyc(1'b0, 1'b0, 1'b0);
    sensor = 4'b0000;
    checks++; if (estado !== 3'd3) begin errors++;
      $display("FAIL sensor_estado_entrada: got %0d want 3", estado); end
    checks++; if (tempo_restante !== 9'd2) begin errors++;
      $display("FAIL sensor_tempo2: got %0d want 2", tempo_restante); end
    checks++; if (armado !== 1'b1) begin errors++;
      $display("FAIL sensor_armado_entrada: got %b want 1", armado); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (tempo_restante !== 9'd1) begin errors++;
      $display("FAIL sensor_tempo1: got %0d want 1", tempo_restante); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (estado !== 3'd4) begin errors++;
      $display("FAIL sensor_estado_disparo: got %0d want 4", estado); end
    checks++; if (sirene !== 1'b1) begin errors++;
      $display("FAIL sensor_sirene_on: got %b want 1", sirene); end
    checks++; if (tempo_restante !== 9'd4) begin errors++;
      $display("FAIL sensor_tempo_sirene: got %0d want 4", tempo_restante); end
    checks++; if (armado !== 1'b0) begin errors++;
      $display("FAIL sensor_armado_disparo: got %b want 0", armado); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (tempo_restante !== 9'(3 - i)) begin errors++;
        $display("FAIL sensor_sirene_count: got %0d want %0d", tempo_restante, 3 - i); end
    end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (estado !== 3'd2) begin errors++;
      $display("FAIL sensor_back_armado: got %0d want 2", estado); end
    checks++; if (sirene !== 1'b0) begin errors++;
      $display("FAIL sensor_sirene_off: got %b want 0", sirene); end
  endtask

  task automatic test_lockout();
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (tentativas !== 2'd1) begin errors++;
      $display("FAIL lock_tent1: got %0d want 1", tentativas); end
    checks++; if (estado !== 3'd2) begin errors++;
      $display("FAIL lock_estado_after1: got %0d want 2", estado); end
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (tentativas !== 2'd2) begin errors++;
      $display("FAIL lock_tent2: got %0d want 2", tentativas); end
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (tentativas !== 2'd0) begin errors++;
      $display("FAIL lock_tent_wrap: got %0d want 0", tentativas); end
    checks++; if (bloqueado !== 1'b1) begin errors++;
      $display("FAIL lock_bloqueado_on: got %b want 1", bloqueado); end
    checks++; if (estado !== 3'd4) begin errors++;
      $display("FAIL lock_estado_disparo: got %0d want 4", estado); end
    checks++; if (tempo_restante !== 9'd4) begin errors++;
      $display("FAIL lock_tempo_sirene: got %0d want 4", tempo_restante); end
    // A valid password while locked out must be ignored.
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (estado !== 3'd4) begin errors++;
      $display("FAIL lock_ignored_estado: got %0d want 4", estado); end
    checks++; if (limpa_digitos !== 1'b0) begin errors++;
      $display("FAIL lock_ignored_limpa: got %b want 0", limpa_digitos); end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (bloqueado !== 1'b1) begin errors++;
      $display("FAIL lock_still_on_4ticks: got %b want 1", bloqueado); end
    checks++; if (estado !== 3'd2) begin errors++;
      $display("FAIL lock_sirene_done: got %0d want 2", estado); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (bloqueado !== 1'b0) begin errors++;
      $display("FAIL lock_off_5ticks: got %b want 0", bloqueado); end
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (tentativas !== 2'd1) begin errors++;
      $display("FAIL lock_accepts_again: got %0d want 1", tentativas); end
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (estado !== 3'd0) begin errors++;
      $display("FAIL lock_disarm: got %0d want 0", estado); end
    checks++; if (tentativas !== 2'd0) begin errors++;
      $display("FAIL lock_valid_clears: got %0d want 0", tentativas); end
  endtask

  task automatic test_panic();
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if ((estado !== 3'd1) || (tentativas !== 2'd1)) begin errors++;
      $display("FAIL panic_setup: got estado %0d tent %0d want 1 1", estado, tentativas); end
    panico = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (estado !== 3'd4) begin errors++;
      $display("FAIL panic_wins_estado: got %0d want 4", estado); end
    checks++; if (tempo_restante !== 9'd4) begin errors++;
      $display("FAIL panic_tempo: got %0d want 4", tempo_restante); end
    checks++; if (tentativas !== 2'd0) begin errors++;
      $display("FAIL panic_tent_clear: got %0d want 0", tentativas); end
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (tempo_restante !== 9'd4) begin errors++;
      $display("FAIL panic_held_reload: got %0d want 4", tempo_restante); end
    panico = 1'b0;
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if ((estado !== 3'd0) || (sirene !== 1'b0) || (tempo_restante !== 9'd0)) begin
      errors++;
      $display("FAIL panic_disarm: got estado %0d sirene %b tempo %0d want 0 0 0",
               estado, sirene, tempo_restante);
    end
  endtask

  task automatic test_valid_tick();
    watch_sirene = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    sensor = 4'b0001;
    cyc(1'b0, 1'b0, 1'b0);
    sensor = 4'b0000;
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if ((estado !== 3'd3) || (tempo_restante !== 9'd1)) begin errors++;
      $display("FAIL vt_setup: got estado %0d tempo %0d want 3 1", estado, tempo_restante); end
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (estado !== 3'd0) begin errors++;
      $display("FAIL vt_estado: got %0d want 0", estado); end
    checks++; if (tempo_restante !== 9'd0) begin errors++;
      $display("FAIL vt_tempo: got %0d want 0", tempo_restante); end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (estado !== 3'd0) begin errors++;
      $display("FAIL vt_stays_desarmado: got %0d want 0", estado); end
    checks++; if (saw_sirene !== 1'b0) begin errors++;
      $display("FAIL vt_sirene_never: got %b want 0", saw_sirene); end
    watch_sirene = 1'b0;
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b1, 1'b0);
    panico = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    panico = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if ((estado !== 3'd4) || (tempo_restante !== 9'd3) || (tentativas !== 2'd1)) begin
      errors++;
      $display("FAIL ar_setup: got estado %0d tempo %0d tent %0d want 4 3 1",
               estado, tempo_restante, tentativas);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (estado !== 3'd0) begin errors++;
      $display("FAIL ar_estado: got %0d want 0", estado); end
    checks++; if ((sirene !== 1'b0) || (armado !== 1'b0) || (bloqueado !== 1'b0)) begin
      errors++;
      $display("FAIL ar_flags: got sirene %b armado %b bloq %b want 0 0 0",
               sirene, armado, bloqueado);
    end
    checks++; if ((tempo_restante !== 9'd0) || (tentativas !== 2'd0)) begin errors++;
      $display("FAIL ar_counts: got tempo %0d tent %0d want 0 0", tempo_restante, tentativas); end
    checks++; if (limpa_digitos !== 1'b0) begin errors++;
      $display("FAIL ar_limpa: got %b want 0", limpa_digitos); end
    // Confirma already present on the first edge after release is honoured.
    confirma = 1'b1; senha_igual = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    confirma = 1'b0; senha_igual = 1'b0;
    checks++; if ((estado !== 3'd1) || (tempo_restante !== 9'd3)) begin errors++;
      $display("FAIL ar_first_edge: got estado %0d tempo %0d want 1 3", estado, tempo_restante); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_sensor();
    test_lockout();
    test_panic();
    test_valid_tick();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_alarme.md
CONTROLE_ALARME -- requirements
Module: controle_alarme

Interface
REQ-001 Parameter TEMPO_SAIDA, default 180, exit delay in seconds (1..511).
REQ-002 Parameter TEMPO_ENTRADA, default 30, entry delay in seconds (1..511).
REQ-003 Parameter TEMPO_SIRENE, default 300, siren duration in seconds (1..511).
REQ-004 Parameter MAX_TENTATIVAS, default 3, wrong-password count that triggers lockout (1..3).
REQ-005 Parameter TEMPO_BLOQUEIO, default 60, lockout duration in seconds (1..63).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
tick_1s  in  1  one-cycle enable pulse, once per second
confirma  in  1  one-cycle pulse, user confirms entered digits
senha_igual  in  1  level, entered digits equal stored password (sampled with confirma)
sensor  in  4  zone sensors, active-high level
panico  in  1  panic button, active-high level
estado  out  3  current FSM state code
armado  out  1  high in ARMADO and ENTRADA
sirene  out  1  high in DISPARO only
bloqueado  out  1  high while lockout active
tempo_restante  out  9  seconds left in active timed state, else 0
tentativas  out  2  current wrong-attempt count
limpa_digitos  out  1  one-cycle pulse clearing user digit counters

Function
REQ-007 States SHALL be DESARMADO=0, SAIDA=1, ARMADO=2, ENTRADA=3, DISPARO=4; codes 5-7 SHALL return to DESARMADO on next edge.
REQ-008 "Accepted confirma" = confirma & ~bloqueado; "valid" = accepted & senha_igual; "wrong" = accepted & ~senha_igual.
REQ-009 Per-cycle priority SHALL be: panico, then valid, then lockout entry, then sensor, then timer expiry.
REQ-010 panico in any state SHALL go to DISPARO, load TEMPO_SIRENE; held panico reloads every cycle.
REQ-011 DESARMADO: valid -> SAIDA, load TEMPO_SAIDA.
REQ-012 SAIDA, ARMADO, ENTRADA, DISPARO: valid -> DESARMADO, tempo_restante=0.
REQ-013 ARMADO: any sensor bit high -> ENTRADA, load TEMPO_ENTRADA; sensors ignored in DESARMADO and SAIDA.
REQ-014 Timed states decrement tempo_restante by 1 on tick_1s only; a tick with tempo_restante==1 SHALL expire: SAIDA -> ARMADO, ENTRADA -> DISPARO (load TEMPO_SIRENE), DISPARO -> ARMADO; tempo_restante 0 in ARMADO.
REQ-015 Valid and tick in same cycle: transition of REQ-011/012 wins, no decrement.
REQ-016 Valid SHALL clear tentativas to 0.
REQ-017 Wrong SHALL increment tentativas; when increment reaches MAX_TENTATIVAS, tentativas=0, bloqueado=1, lockout counter loads TEMPO_BLOQUEIO, and state ARMADO or ENTRADA SHALL go to DISPARO (load TEMPO_SIRENE); other states unchanged.
REQ-018 Lockout counter SHALL decrement on tick_1s independently of FSM; bloqueado clears on the tick reaching 0; confirma while bloqueado SHALL be ignored (no count, no pulse).
REQ-019 limpa_digitos SHALL pulse exactly one cycle, the cycle after every accepted confirma.
REQ-020 All outputs SHALL be registered; state/output change visible the cycle after the sampling edge (latency 1).

Reset
REQ-021 reset_n low SHALL immediately force: estado=DESARMADO, armado=0, sirene=0, bloqueado=0, tempo_restante=0, tentativas=0, limpa_digitos=0, lockout counter=0, regardless of clock or current timed state.
REQ-022 After reset_n deasserts, first edge SHALL evaluate inputs normally; a confirma coinciding with deassertion edge is honoured.

Structure
REQ-023 State codes and parameter defaults SHALL live in shared package alarme_pkg.
REQ-024 One sub-module contador_regressivo (loadable 9-bit down-counter with tick enable, load, clear, zero flag) SHALL be instantiated twice: FSM timer and lockout timer.

Verification (bench uses TEMPO_SAIDA=3, TEMPO_ENTRADA=2, TEMPO_SIRENE=4, TEMPO_BLOQUEIO=5, MAX_TENTATIVAS=3)
REQ-025 Valid confirma in DESARMADO, 3 ticks -> SAIDA with tempo_restante 3,2,1, then ARMADO, armado=1, limpa_digitos one pulse.
REQ-026 ARMADO, sensor=4'b0100, 2 ticks -> ENTRADA, then DISPARO, sirene=1, tempo_restante=4; 4 ticks -> ARMADO, sirene=0.
REQ-027 Three wrong confirma in ARMADO -> tentativas 1,2,0, bloqueado=1, DISPARO; confirma during lockout no effect; 5 ticks -> bloqueado=0.
REQ-028 panico and valid confirma same cycle in SAIDA -> DISPARO, tempo_restante=4, tentativas=0.
REQ-029 valid confirma and tick same cycle in ENTRADA tempo_restante=1 -> DESARMADO, sirene never asserted.
REQ-030 reset_n low mid-DISPARO between clock edges -> all outputs 0, estado=0 asynchronously.
